// File: rtl/obs_pkg.sv
// Shared observation types for the codeblock wrappers, the stutter filter and the trace comparator.
package obs_pkg;

    localparam int unsigned OBS_W = 2;

    // bit1 = a, bit0 = b
    typedef logic [OBS_W-1:0] obs_t;

    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/obs_stutter_filter_if.sv
// Observation input and buffered trace output port of the stutter filter.
interface obs_stutter_filter_if
    import obs_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LVL_W = lvl_w(DEPTH);

    obs_t             in_obs;
    logic             in_stutter;
    logic             out_valid;
    logic             out_ready;
    obs_t             out_obs;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             settled;

    // Filter side
    modport slave (
        input  in_obs,
        input  in_stutter,
        input  out_ready,
        output out_valid,
        output out_obs,
        output level,
        output overflow,
        output settled
    );

    // Source and consumer side
    modport master (
        output in_obs,
        output in_stutter,
        output out_ready,
        input  out_valid,
        input  out_obs,
        input  level,
        input  overflow,
        input  settled
    );

endinterface

// File: rtl/obs_fifo.sv
// Circular buffer of observations; head, level and flags are all registered.
module obs_fifo
    import obs_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  obs_t                    din_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output obs_t                    head_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    obs_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    obs_t             head_q, head_d;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full buffer is only taken when the head leaves at the same edge.
    always_comb begin
        pop_ok  = pop_i & ~empty_q;
        push_ok = push_i & (~full_q | pop_ok);
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        head_d  = head_q;

        if (push_ok) begin
            wr_d = PTR_W'(wr_q + 1'b1);
        end
        if (pop_ok) begin
            rd_d = PTR_W'(rd_q + 1'b1);
        end

        case ({push_ok, pop_ok})
            2'b10:   level_d = LVL_W'(level_q + 1'b1);
            2'b01:   level_d = LVL_W'(level_q - 1'b1);
            default: level_d = level_q;
        endcase

        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);

        // The next head may be the entry being written this edge.
        if (empty_d) begin
            head_d = '0;
        end else if (push_ok && (rd_d == wr_q)) begin
            head_d = din_i;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;
    assign head_o  = head_q;

endmodule

// File: rtl/obs_stutter_filter.sv
// Reduces a codeblock observation stream to its stutter-free change trace and buffers it for the comparator.
module obs_stutter_filter
    import obs_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SETTLE_CYC = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    obs_stutter_filter_if.slave   bus
);
    localparam int unsigned LVL_W = lvl_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

    obs_t             last_obs_q, last_obs_d;
    logic             seen_first_q, seen_first_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic             settled_q, settled_d;
    logic             overflow_q, overflow_d;

    logic             push_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    obs_t             fifo_head;
    logic             pop_eff;

    // Compression tracks the input trace even when the buffer drops the push.
    always_comb begin
        last_obs_d   = last_obs_q;
        seen_first_d = seen_first_q;
        settle_cnt_d = settle_cnt_q;
        settled_d    = settled_q;
        overflow_d   = overflow_q;
        push_req     = 1'b0;
        pop_eff      = bus.out_ready & ~fifo_empty;

        if (!bus.in_stutter) begin
            if (!seen_first_q || (bus.in_obs != last_obs_q)) begin
                push_req     = 1'b1;
                last_obs_d   = bus.in_obs;
                seen_first_d = 1'b1;
                settle_cnt_d = '0;
                settled_d    = 1'b0;
            end else begin
                if (settle_cnt_q != CNT_W'(SETTLE_CYC)) begin
                    settle_cnt_d = CNT_W'(settle_cnt_q + 1'b1);
                end
                if (settle_cnt_d == CNT_W'(SETTLE_CYC)) begin
                    settled_d = 1'b1;
                end
            end
        end

        if (push_req && fifo_full && !pop_eff) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_obs_q   <= '0;
            seen_first_q <= 1'b0;
            settle_cnt_q <= '0;
            settled_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            last_obs_q   <= last_obs_d;
            seen_first_q <= seen_first_d;
            settle_cnt_q <= settle_cnt_d;
            settled_q    <= settled_d;
            overflow_q   <= overflow_d;
        end
    end

    obs_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .pop_i   (bus.out_ready),
        .din_i   (bus.in_obs),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level),
        .head_o  (fifo_head)
    );

    assign bus.out_valid = ~fifo_empty;
    assign bus.out_obs   = fifo_head;
    assign bus.level     = fifo_level;
    assign bus.overflow  = overflow_q;
    assign bus.settled   = settled_q;

endmodule

// File: tb/tb_obs_stutter_filter.sv
// Scoreboard bench: driver models the change trace and queues expected entries, negedge monitor checks the port.
module tb_obs_stutter_filter;
    import obs_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obs_stutter_filter_if #(.DEPTH(DEPTH)) bus ();

    obs_stutter_filter #(
        .DEPTH      (DEPTH),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: expected buffer contents plus committed/next flag values
    obs_t exp_q[$];
    bit   pend    = 1'b0;
    bit   cur_ovf = 1'b0, nxt_ovf = 1'b0;
    bit   cur_set = 1'b0, nxt_set = 1'b0;
    obs_t m_last  = '0;
    bit   m_seen  = 1'b0;
    int   m_run   = 0;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endfunction

    // Inputs for the next edge, and the model's view of what that edge does.
    task automatic step(input obs_t o, input bit st, input bit rd);
        bit pop_will;
        @(posedge clk);
        #2;
        bus.in_obs     = o;
        bus.in_stutter = st;
        bus.out_ready  = rd;
        pend     = 1'b0;
        nxt_ovf  = cur_ovf;
        nxt_set  = cur_set;
        pop_will = (exp_q.size() > 0) && rd;
        if (!st) begin
            if (!m_seen || (o != m_last)) begin
                m_last  = o;
                m_seen  = 1'b1;
                m_run   = 0;
                nxt_set = 1'b0;
                if ((exp_q.size() < int'(DEPTH)) || pop_will) begin
                    exp_q.push_back(o);
                    pend = 1'b1;
                end else begin
                    nxt_ovf = 1'b1;
                end
            end else begin
                m_run++;
                nxt_set = (m_run >= int'(SETTLE));
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        pend    = 1'b0;
        cur_ovf = 1'b0; nxt_ovf = 1'b0;
        cur_set = 1'b0; nxt_set = 1'b0;
        m_last  = '0;
        m_seen  = 1'b0;
        m_run   = 0;
        bus.in_stutter = 1'b1;
        bus.out_ready  = 1'b0;
        #1;
        chk("rst_valid",    int'(bus.out_valid), 0);
        chk("rst_level",    int'(bus.level),     0);
        chk("rst_obs",      int'(bus.out_obs),   0);
        chk("rst_overflow", int'(bus.overflow),  0);
        chk("rst_settled",  int'(bus.settled),   0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: outputs reflect the last edge; a ready head leaves at the next edge.
    int committed;
    always @(negedge clk) begin
        committed = exp_q.size() - int'(pend);
        chk("level",    int'(bus.level),     committed);
        chk("valid",    int'(bus.out_valid), int'(committed != 0));
        chk("overflow", int'(bus.overflow),  int'(cur_ovf));
        chk("settled",  int'(bus.settled),   int'(cur_set));
        if (committed == 0) begin
            chk("obs_empty", int'(bus.out_obs), 0);
        end else begin
            chk("head", int'(bus.out_obs), int'(exp_q[0]));
            if (bus.out_ready && rst_n) begin
                void'(exp_q.pop_front());
            end
        end
        cur_ovf = nxt_ovf;
        cur_set = nxt_set;
        pend    = 1'b0;
    end

    obs_t seq3 [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

    initial begin
        obs_t o;
        bus.in_obs     = '0;
        bus.in_stutter = 1'b1;
        bus.out_ready  = 1'b0;
        #12;
        rst_n = 1'b1;

        // Held value: one push, then settles
        repeat (5) step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b1);
        step(2'b00, 1'b1, 1'b0);
        do_reset();

        // Stutter on a repeat with a ready consumer
        step(2'b00, 1'b0, 1'b1);
        step(2'b10, 1'b0, 1'b1);
        step(2'b10, 1'b1, 1'b1);
        step(2'b11, 1'b0, 1'b1);
        repeat (3) step(2'b11, 1'b1, 1'b1);
        do_reset();

        // Fill, drop the fifth, drain
        for (int i = 0; i < 5; i++) step(seq3[i], 1'b0, 1'b0);
        repeat (6) step(2'b01, 1'b1, 1'b1);
        do_reset();

        // Full buffer with a simultaneous pop accepts the push
        for (int i = 0; i < 4; i++) step(seq3[i], 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b1);
        step(2'b11, 1'b1, 1'b0);
        repeat (5) step(2'b11, 1'b1, 1'b1);
        do_reset();

        // Asynchronous reset at level 3; matching value afterwards is still first
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        do_reset();
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b1);
        step(2'b11, 1'b1, 1'b0);
        do_reset();

        // All stutter
        repeat (10) step(obs_t'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
        do_reset();

        // Randomised trace with repeats, stutters, back-pressure and occasional reset
        o = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) o = obs_t'($urandom_range(0, 3));
            step(o, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0 || (i % 50) > 40));
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        repeat (8) step('0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
